dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder end of the core's data-memory load/store interface: byte-addressable RAM
//  serving 32-bit word reads and byte-enabled writes over a valid/ready request/response handshake.
//  Sits between the core's memory stage (initiator) and the RAM array.
//  Configurable access latency models slow memory so the core's stall logic can be exercised.
//  One outstanding transaction at a time.
// PARAMETERS
//  ADDR_W   7   byte-address width; memory depth = 2**ADDR_W bytes (default 128)
//  LATENCY  1   extra wait cycles between accept and response, 0..15
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  req_valid  in   1       initiator presents a request
//  req_ready  out  1       responder can accept a request this cycle
//  req_write  in   1       1 = store, 0 = load
//  req_addr   in   ADDR_W  byte address; must be word-aligned
//  req_wdata  in   32      store data, little-endian: byte addr+0 = wdata[7:0]
//  req_be     in   4       store byte enables; be[i] selects wdata[8i+7:8i]; ignored for loads
//  rsp_valid  out  1       response available
//  rsp_ready  in   1       initiator accepts response
//  rsp_rdata  out  32      load data, little-endian; 0 for stores and errors
//  rsp_err    out  1       request was misaligned
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, wait counter 0, req_ready 0 while rst high,
//   rsp_valid 0, rsp_rdata 0, rsp_err 0. RAM contents are NOT reset.
//  FSM: IDLE -> (accept) -> WAIT if LATENCY>0, else RESP; WAIT -> RESP when counter expires;
//   RESP -> IDLE on rsp_valid && rsp_ready.
//  IDLE: req_ready=1. Accept = req_valid && req_ready; latch write, addr, wdata, be; load counter = LATENCY.
//  WAIT: req_ready=0; counter decrements each cycle; on the edge where it leaves WAIT it performs the access.
//  Access edge: the edge entering RESP. Load: rsp_rdata <= {m[a+3],m[a+2],m[a+1],m[a]}.
//   Store: m[a+i] <= wdata byte i for each be[i]=1; rsp_rdata <= 0. Misaligned (addr[1:0]!=0):
//   no RAM change, rsp_rdata <= 0, rsp_err <= 1; otherwise rsp_err <= 0.
//  Timing: accept in cycle n -> rsp_valid high in cycle n+1+LATENCY. With rsp_ready high,
//   req_ready high again in cycle n+2+LATENCY (max throughput 1 req / LATENCY+2 cycles).
//  RESP: rsp_valid=1, rsp_rdata/rsp_err held stable until handshake; req_ready=0; req_valid ignored.
//  rsp_valid drops the cycle after handshake; rsp_rdata/rsp_err retain values (don't-care when invalid).
//  Addresses are ADDR_W bits, full decode; aligned word never crosses the array end (no wrap needed).
//  Store with be=4'b0000: legal, no RAM change, rsp_err=0.
//  Store then load of same address: load accepted after store response sees new data.
//  Reset mid-transaction: before access edge -> store aborted, RAM unchanged; after -> write persists.
//   Pending response is discarded.
// TESTING
//  1 LATENCY=2: store 0xDEADBEEF @0x10 be=F accepted cycle n -> rsp_valid in n+3, err=0;
//    then load @0x10 -> rsp_rdata=0xDEADBEEF.
//  2 Byte enables: over 0xDEADBEEF, store 0x11223344 be=4'b0101 @0x10 -> load returns 0xDE22BE44.
//  3 Misaligned load @0x12 and store @0x13 -> rsp_err=1, rdata=0; load @0x10 still 0xDE22BE44.
//  4 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0,
//    concurrent req_valid not accepted; accepted after handshake.
//  5 Edges: LATENCY=0 store/load @0x7C (top word) -> response next cycle, data 0xCAFEF00D;
//    byte order: store 0x04030201, read bytes m[0x7C..0x7F]=01,02,03,04.
//  6 Reset in WAIT of store 0x55555555 @0x20 (old 0) -> rsp_valid 0, req_ready 1 after release,
//    load @0x20 -> 0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the core's data-memory load/store port.
// A byte-addressable RAM that serves 32-bit little-endian word loads and
// byte-enabled stores. Requests and responses each use a valid/ready
// handshake, and only one transaction is outstanding at a time. LATENCY
// inserts wait cycles between accept and response to model slow memory.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    request can be accepted this cycle
//   req_write_i    1 = store, 0 = load
//   req_addr_i     byte address, must be word-aligned
//   req_wdata_i    store data, byte addr+0 = wdata[7:0]
//   req_be_i       store byte enables (ignored for loads)
//   rsp_valid_o    response present
//   rsp_ready_i    initiator accepts response
//   rsp_rdata_o    load data; 0 for stores and misaligned requests
//   rsp_err_o      request was misaligned
//
// state  | meaning
// S_IDLE | ready for a request
// S_WAIT | request latched, counting down LATENCY cycles
// S_RESP | access done, holding response until rsp_ready_i
module dmem_responder #(
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_be_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              accept;
  logic              access;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  logic [31:0]       rdata_q;
  logic              err_q;

  logic [7:0]        mem_q [0:(2**ADDR_W)-1];

  // With LATENCY=0 the access happens on the accept edge itself, before
  // the request has been latched, so the access operands come straight
  // from the request port while in IDLE.
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic              acc_aligned;
  logic [ADDR_W-3:0] acc_word;
  logic [31:0]       rd_word;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_o = 1'b0;
    accept      = 1'b0;
    access      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // req_ready must stay low for as long as reset is held.
        req_ready_o = ~rst_i;
        if (req_valid_i && !rst_i) begin
          accept = 1'b1;
          if (LAT == 4'd0) begin
            state_d = S_RESP;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Counter holds LATENCY on entry, so leaving at 1 gives exactly
        // LATENCY cycles in WAIT.
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
          access  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (accept) begin
      wr_q    <= req_write_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      be_q    <= req_be_i;
    end
  end

  always_comb begin
    if (state_q == S_IDLE) begin
      acc_write = req_write_i;
      acc_addr  = req_addr_i;
      acc_wdata = req_wdata_i;
      acc_be    = req_be_i;
    end else begin
      acc_write = wr_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  assign acc_aligned = (acc_addr[1:0] == 2'b00);
  assign acc_word    = acc_addr[ADDR_W-1:2];
  assign rd_word     = {mem_q[{acc_word, 2'd3}], mem_q[{acc_word, 2'd2}],
                        mem_q[{acc_word, 2'd1}], mem_q[{acc_word, 2'd0}]};

  // RAM contents survive reset; an access can only fire outside reset.
  always_ff @(posedge clk_i) begin
    if (access && acc_write && acc_aligned) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem_q[{acc_word, 2'(i)}] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access) begin
      err_q   <= ~acc_aligned;
      rdata_q <= (acc_aligned && !acc_write) ? rd_word : 32'h0;
    end
  end

  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Instance 0 uses LATENCY=2 and
// instance 1 uses LATENCY=0; both share one clock.
module tb_dmem_responder;

  logic        clk;
  logic [1:0]  rst;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [6:0]  req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic [31:0] rsp_rdata [2];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.ADDR_W(7), .LATENCY(2)) u_l2 (
    .clk_i(clk), .rst_i(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_write_i(req_write[0]), .req_addr_i(req_addr[0]),
    .req_wdata_i(req_wdata[0]), .req_be_i(req_be[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  dmem_responder #(.ADDR_W(7), .LATENCY(0)) u_l0 (
    .clk_i(clk), .rst_i(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_write_i(req_write[1]), .req_addr_i(req_addr[1]),
    .req_wdata_i(req_wdata[1]), .req_be_i(req_be[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction with rsp_ready held high. lat is the number of
  // cycles from the accept cycle to the first cycle with rsp_valid high.
  task automatic transact(input int d, input logic wr, input logic [6:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_be[d]    = be;
    rsp_ready[d] = 1'b1;
    guard = 0;
    while (!req_ready[d] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[d]) check("accept_timeout", {31'b0, req_ready[d]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd  = rsp_rdata[d];
    err = rsp_err[d];
    @(posedge clk);
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          guard;

  initial begin
    rst       = 2'b11;
    req_valid = '0;
    req_write = '0;
    rsp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d]  = '0;
      req_wdata[d] = '0;
      req_be[d]    = '0;
    end

    // Reset state
    #1;
    check("rst_req_ready", {30'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata[0], 32'h0);
    check("rst_err", {30'b0, rsp_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 2'b00;
    #1;
    check("rel_req_ready", {30'b0, req_ready}, 32'd3);

    // 1: LATENCY=2 store then load
    transact(0, 1'b1, 7'h10, 32'hDEADBEEF, 4'hF, rd, err, lat);
    check("t1_st_lat", lat, 32'd3);
    check("t1_st_err", {31'b0, err}, 32'd0);
    check("t1_st_rdata", rd, 32'h0);
    @(negedge clk);
    check("t1_rsp_drop", {31'b0, rsp_valid[0]}, 32'd0);
    check("t1_ready_back", {31'b0, req_ready[0]}, 32'd1);
    transact(0, 1'b0, 7'h10, 32'h0, 4'h0, rd, err, lat);
    check("t1_ld_lat", lat, 32'd3);
    check("t1_ld_rdata", rd, 32'hDEADBEEF);

    // 2: byte enables
    transact(0, 1'b1, 7'h10, 32'h11223344, 4'b0101, rd, err, lat);
    transact(0, 1'b0, 7'h10, 32'h0, 4'h0, rd, err, lat);
    check("t2_be_merge", rd, 32'hDE22BE44);

    // 3: misaligned and empty byte enables
    transact(0, 1'b0, 7'h12, 32'h0, 4'h0, rd, err, lat);
    check("t3_ld_mis_err", {31'b0, err}, 32'd1);
    check("t3_ld_mis_rdata", rd, 32'h0);
    transact(0, 1'b1, 7'h13, 32'hFFFFFFFF, 4'hF, rd, err, lat);
    check("t3_st_mis_err", {31'b0, err}, 32'd1);
    check("t3_st_mis_rdata", rd, 32'h0);
    transact(0, 1'b1, 7'h10, 32'h0, 4'h0, rd, err, lat);
    check("t3_be0_err", {31'b0, err}, 32'd0);
    transact(0, 1'b0, 7'h10, 32'h0, 4'h0, rd, err, lat);
    check("t3_ld_after", rd, 32'hDE22BE44);
    check("t3_ld_after_err", {31'b0, err}, 32'd0);

    // 4: backpressure with a competing request held during RESP
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b0;
    req_addr[0]  = 7'h10;
    check("t4_ready_idle", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_write[0] = 1'b1;
    req_wdata[0] = 32'h0;
    req_be[0]    = 4'hF;
    guard = 0;
    while (!rsp_valid[0] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      check("t4_hold_valid", {31'b0, rsp_valid[0]}, 32'd1);
      check("t4_hold_rdata", rsp_rdata[0], 32'hDE22BE44);
      check("t4_hold_ready", {31'b0, req_ready[0]}, 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_after_valid", {31'b0, rsp_valid[0]}, 32'd0);
    check("t4_after_ready", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    guard = 0;
    while (!rsp_valid[0] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("t4_st_valid", {31'b0, rsp_valid[0]}, 32'd1);
    check("t4_st_rdata", rsp_rdata[0], 32'h0);
    @(posedge clk);
    transact(0, 1'b0, 7'h10, 32'h0, 4'h0, rd, err, lat);
    check("t4_ld_new", rd, 32'h0);

    // 5: LATENCY=0, top word, byte order
    transact(1, 1'b1, 7'h7C, 32'hCAFEF00D, 4'hF, rd, err, lat);
    check("t5_st_lat", lat, 32'd1);
    check("t5_st_err", {31'b0, err}, 32'd0);
    transact(1, 1'b0, 7'h7C, 32'h0, 4'h0, rd, err, lat);
    check("t5_ld_lat", lat, 32'd1);
    check("t5_ld_rdata", rd, 32'hCAFEF00D);
    transact(1, 1'b1, 7'h7C, 32'h04030201, 4'hF, rd, err, lat);
    transact(1, 1'b0, 7'h7C, 32'h0, 4'h0, rd, err, lat);
    check("t5_order", rd, 32'h04030201);
    transact(1, 1'b1, 7'h7C, 32'h000000FF, 4'b0001, rd, err, lat);
    transact(1, 1'b0, 7'h7C, 32'h0, 4'h0, rd, err, lat);
    check("t5_byte0", rd, 32'h040302FF);
    transact(1, 1'b1, 7'h7C, 32'hAA000000, 4'b1000, rd, err, lat);
    transact(1, 1'b0, 7'h7C, 32'h0, 4'h0, rd, err, lat);
    check("t5_byte3", rd, 32'hAA0302FF);

    // 6: reset during WAIT aborts the store
    transact(0, 1'b1, 7'h20, 32'h0, 4'hF, rd, err, lat);
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 7'h20;
    req_wdata[0] = 32'h55555555;
    req_be[0]    = 4'hF;
    check("t6_ready", {31'b0, req_ready[0]}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    #1;
    check("t6_rst_valid", {31'b0, rsp_valid[0]}, 32'd0);
    check("t6_rst_ready", {31'b0, req_ready[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    #1;
    check("t6_rel_ready", {31'b0, req_ready[0]}, 32'd1);
    repeat (3) @(negedge clk);
    check("t6_rel_valid", {31'b0, rsp_valid[0]}, 32'd0);
    transact(0, 1'b0, 7'h20, 32'h0, 4'h0, rd, err, lat);
    check("t6_ld_old", rd, 32'h0);
    check("t6_ld_lat", lat, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
